// File: rtl/seq_divider_fx.sv
// Unsigned fixed-point restoring divider, one quotient bit per clock: quotient = floor(dividend * 2^FRAC_W / divisor).
// Optional macro SEQ_DIVIDER_FX_SIGNED_EN adds a signed_mode port with a sign fix-up cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_LOAD   | clear partial remainder/counter, load shift register, trap divisor==0
// S_DIVIDE | one restoring step per cycle, N cycles
// S_FIX    | signed build only: apply result signs
// S_DONE   | results valid, done pulse; start accepted back-to-back
module seq_divider_fx #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 16,
  parameter int FRAC_W     = 8,
  localparam int N         = DIVIDEND_W + FRAC_W
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
  input  logic                 signed_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         quotient,
  output logic [DIVISOR_W-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIVIDE, S_FIX, S_DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [N-1:0]          shreg;
  logic [DIVISOR_W:0]    p;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    p_shift;
  logic [DIVISOR_W:0]    p_next;
  logic                  q_bit;
  logic [N-1:0]          dz_quot;

  // p[DIVISOR_W] is always 0 between steps (P < divisor); folding it into the
  // compare keeps the step correct for the full-width {P, msb} value.
  assign p_shift = {p[DIVISOR_W-1:0], shreg[N-1]};
  assign q_bit   = p[DIVISOR_W] | (p_shift >= {1'b0, dvs_q});
  assign p_next  = q_bit ? (p_shift - {1'b0, dvs_q}) : p_shift;

`ifdef SEQ_DIVIDER_FX_SIGNED_EN
  logic a_neg, b_neg;
  logic sgn_q, neg_q, neg_r;
  assign a_neg   = signed_mode & dividend[DIVIDEND_W-1];
  assign b_neg   = signed_mode & divisor[DIVISOR_W-1];
  assign dz_quot = !sgn_q ? {N{1'b1}} :
                   neg_r  ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
  assign dz_quot = {N{1'b1}};
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      shreg       <= '0;
      p           <= '0;
      cnt         <= '0;
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
            // Magnitudes go through the unsigned core; signs are reapplied in S_FIX.
            dvd_q <= a_neg ? -dividend : dividend;
            dvs_q <= b_neg ? -divisor : divisor;
            sgn_q <= signed_mode;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
`else
            dvd_q <= dividend;
            dvs_q <= divisor;
`endif
            busy  <= 1'b1;
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          p     <= '0;
          cnt   <= '0;
          shreg <= N'(dvd_q) << FRAC_W;
          if (dvs_q == '0) begin
            quotient    <= dz_quot;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_DONE;
          end else begin
            state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          p     <= p_next;
          shreg <= {shreg[N-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            busy <= 1'b0;
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
            if (sgn_q) state <= S_FIX;
            else
`endif
            begin
              quotient    <= {shreg[N-2:0], q_bit};
              remainder   <= p_next[DIVISOR_W-1:0];
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
        S_FIX: begin
          quotient    <= neg_q ? -shreg : shreg;
          remainder   <= neg_r ? -p[DIVISOR_W-1:0] : p[DIVISOR_W-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_fx.sv
// Directed self-checking bench for seq_divider_fx with hand-computed results.
// Signed vectors run only when SEQ_DIVIDER_FX_SIGNED_EN is defined.
module tb_seq_divider_fx;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        signed_mode = 1'b0;
  logic        busy, done, div_by_zero;
  logic [23:0] quotient;
  logic [15:0] remainder;

  int n_chk = 0;
  int n_fail = 0;
  int lat, lat2, n_done;

  always #5 clk = ~clk;

  seq_divider_fx dut (
    .clk         (clk),
    .nRst        (nRst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef SEQ_DIVIDER_FX_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle; lat = cycles from the start cycle to the done cycle (-1 on timeout).
  // rp > 0 re-pulses start with other operands in that cycle of the op.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sm, input int rp,
                       output int l);
    @(negedge clk);
    dividend = a; divisor = b; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_load", 32'(busy), 32'd1);
    l = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        l = c;
        break;
      end
      if (c == rp) begin
        dividend = 16'd9; divisor = 16'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [23:0] q, input logic [15:0] r,
                           input logic dz, input int l_exp);
    check_eq({tag, "_lat"}, 32'(lat), 32'(l_exp));
    check_eq({tag, "_q"}, 32'(quotient), 32'(q));
    check_eq({tag, "_r"}, 32'(remainder), 32'(r));
    check_eq({tag, "_dz"}, 32'(div_by_zero), 32'(dz));
  endtask

  initial begin
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_q", 32'(quotient), 32'd0);
    check_eq("rst_r", 32'(remainder), 32'd0);
    check_eq("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    nRst = 1'b1;

    do_op(16'd1000, 16'd3, 1'b0, 0, lat);
    check_res("d1000_3", 24'h014D55, 16'd1, 1'b0, 26);
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);

    do_op(16'd5, 16'd10, 1'b0, 0, lat);
    check_res("d5_10", 24'd128, 16'd0, 1'b0, 26);
    do_op(16'hFFFF, 16'd1, 1'b0, 0, lat);
    check_res("dffff_1", 24'hFFFF00, 16'd0, 1'b0, 26);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 0, lat);
    check_res("dffff_ffff", 24'd256, 16'd0, 1'b0, 26);
    do_op(16'd1, 16'hFFFF, 1'b0, 0, lat);
    check_res("d1_ffff", 24'd0, 16'd256, 1'b0, 26);

    do_op(16'd1234, 16'd0, 1'b0, 0, lat);
    check_res("div0", 24'hFFFFFF, 16'd0, 1'b1, 2);
    do_op(16'd200, 16'd9, 1'b0, 0, lat);
    check_res("after_div0", 24'd5688, 16'd8, 1'b0, 26);

    do_op(16'd1000, 16'd7, 1'b0, 5, lat);
    check_res("repulse", 24'd36571, 16'd3, 1'b0, 26);
    @(negedge clk);
    check_eq("repulse_idle", 32'(busy), 32'd0);

    // start held high: back-to-back results every 26 cycles
    @(negedge clk);
    dividend = 16'd200; divisor = 16'd9; start = 1'b1;
    lat = -1; lat2 = -1;
    for (int c = 0; c <= 80; c++) begin
      if (done && lat < 0) lat = c;
      else if (done && lat2 < 0) begin
        lat2 = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("b2b_first", 32'(lat), 32'd26);
    check_eq("b2b_period", 32'(lat2 - lat), 32'd26);
    check_eq("b2b_q", 32'(quotient), 32'd5688);
    check_eq("b2b_r", 32'(remainder), 32'd8);
    repeat (3) @(negedge clk);

    // reset at iteration 10 of a divide
    do_op(16'd1234, 16'd0, 1'b0, 0, lat);
    @(negedge clk);
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 nRst = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_q", 32'(quotient), 32'd0);
    check_eq("mid_rst_r", 32'(remainder), 32'd0);
    check_eq("mid_rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("no_done_after_rst", 32'(n_done), 32'd0);
    do_op(16'd300, 16'd5, 1'b0, 0, lat);
    check_res("post_rst", 24'd15360, 16'd0, 1'b0, 26);

`ifdef SEQ_DIVIDER_FX_SIGNED_EN
    do_op(16'hFC18, 16'd3, 1'b1, 0, lat);
    check_res("s_m1000_3", 24'hFEB2AB, 16'hFFFF, 1'b0, 27);
    do_op(16'd1000, 16'd3, 1'b0, 0, lat);
    check_res("s_off_1000_3", 24'h014D55, 16'd1, 1'b0, 26);
    do_op(16'hFC18, 16'd0, 1'b1, 0, lat);
    check_res("s_div0_neg", 24'h800000, 16'd0, 1'b1, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
